key_expand_seq: RTL and testbench



---
 rtl/key_expand_seq.sv | 137 +++++++++++++
 tb/tb_key_expand_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_expand_seq.sv
// AES-128 key expansion, one round key per cycle: IDLE -> EXPAND (rounds 0..10) -> DONE.
// Includes the combinational sub_word S-box block used for SubWord.

module sub_word (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                   SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

module key_expand_seq (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [127:0] i_key,
  output logic [127:0] o_round_key,
  output logic [3:0]   o_round_idx,
  output logic         o_key_valid,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  state_t       state, state_nxt;
  logic [127:0] key_q;
  logic [3:0]   cnt_q;
  logic         accept;
  logic [31:0]  rot_w, sub_w, t_w;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_round_key(input logic [127:0] k, input logic [31:0] t);
    logic [31:0] w4, w5, w6, w7;
    w4 = k[127:96] ^ t;
    w5 = k[95:64]  ^ w4;
    w6 = k[63:32]  ^ w5;
    w7 = k[31:0]   ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  // t = SubWord(RotWord(w3)) ^ {Rcon[cnt+1], 0}
  assign rot_w = {key_q[23:0], key_q[31:24]};

  sub_word u_sub_word (
    .i_word (rot_w),
    .o_word (sub_w)
  );

  assign t_w    = sub_w ^ {rcon(cnt_q + 4'd1), 24'h000000};
  assign accept = (state == S_IDLE || state == S_DONE) && i_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (i_start) state_nxt = S_EXPAND;
      S_EXPAND: if (cnt_q == LAST_ROUND) state_nxt = S_DONE;
      S_DONE:   if (i_start) state_nxt = S_EXPAND;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Key register holds the round-10 key through DONE; IDLE is only reachable via reset, so it reads 0 there.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      key_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      key_q <= i_key;
      cnt_q <= '0;
    end else if (state == S_EXPAND && cnt_q < LAST_ROUND) begin
      key_q <= next_round_key(key_q, t_w);
      cnt_q <= cnt_q + 4'd1;
    end
  end

  always_comb begin
    o_key_valid = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (state)
      S_EXPAND: begin
        o_key_valid = 1'b1;
        o_busy      = 1'b1;
      end
      S_DONE:   o_done = 1'b1;
      default:  ;
    endcase
  end

  assign o_round_key = key_q;
  assign o_round_idx = cnt_q;

endmodule

// File: tb/tb_key_expand_seq.sv
// Bench for key_expand_seq: known-answer table, hand-written corner sequences and random keys
// against a key-schedule model whose S-box is derived from GF(2^8) inversion plus the affine map.

module tb_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_rk [11];

  typedef struct {
    logic [127:0] key;
    logic [127:0] r0;
    logic [127:0] r1;
    logic [127:0] r10;
  } vec_t;

  vec_t vecs [2];

  key_expand_seq dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_key       (key),
    .o_round_key (round_key),
    .o_round_idx (round_idx),
    .o_key_valid (key_valid),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic compute_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_ref[tmp[31:24]], sbox_ref[tmp[23:16]], sbox_ref[tmp[15:8]], sbox_ref[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " key"},   round_key, '0);
    check({tag, " idx"},   128'(round_idx), '0);
    check({tag, " valid"}, 128'(key_valid), '0);
    check({tag, " busy"},  128'(busy), '0);
    check({tag, " done"},  128'(done), '0);
  endtask

  // Present key with start for one edge; afterwards i_key is scrambled to prove it is not resampled.
  task automatic accept(input logic [127:0] k);
    compute_model(k);
    key   = k;
    start = 1'b1;
    step();
    start = 1'b0;
    key   = rand_key();
  endtask

  // Called just after the accepting edge; checks rounds 0..10 and the DONE state that follows.
  task automatic check_rounds(input string tag, input int restart_at, input bit tab_en,
                              input logic [127:0] tab_r1, input logic [127:0] tab_r10);
    for (int r = 0; r <= 10; r++) begin
      check($sformatf("%s r%0d key", tag, r),   round_key, exp_rk[r]);
      check($sformatf("%s r%0d idx", tag, r),   128'(round_idx), 128'(r));
      check($sformatf("%s r%0d valid", tag, r), 128'({key_valid, busy, done}), 128'(3'b110));
      if (tab_en && r == 1)  check($sformatf("%s r1 table", tag),  round_key, tab_r1);
      if (tab_en && r == 10) check($sformatf("%s r10 table", tag), round_key, tab_r10);
      if (r == restart_at) begin
        start = 1'b1;
        key   = rand_key();
      end
      step();
      start = 1'b0;
    end
    check({tag, " done key"},   round_key, exp_rk[10]);
    check({tag, " done idx"},   128'(round_idx), 128'd10);
    check({tag, " done flags"}, 128'({key_valid, busy, done}), 128'(3'b001));
  endtask

  initial begin
    logic [127:0] k;
    int           vcount;
    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, r0: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                r1: 128'ha0fafe1788542cb123a339392a6c7605, r10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{key: 128'h0, r0: 128'h0,
                r1: 128'h62636363626363636263636362636363, r10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    build_sbox();

    rst   = 1'b1;
    start = 1'b0;
    key   = '0;
    step();
    step();
    check_idle("reset");
    rst = 1'b0;
    step();
    check_idle("idle hold");

    // Known-answer table; valid must be high for exactly 11 cycles
    for (int v = 0; v < 2; v++) begin
      accept(vecs[v].key);
      check($sformatf("tab%0d r0 table", v), round_key, vecs[v].r0);
      check_rounds($sformatf("tab%0d", v), -1, 1'b1, vecs[v].r1, vecs[v].r10);
    end

    // DONE holds while start stays low
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("done hold%0d key", i), round_key, exp_rk[10]);
      check($sformatf("done hold%0d flags", i), 128'({key_valid, done, round_idx}), 128'({1'b0, 1'b1, 4'd10}));
    end

    // Restart from DONE: o_done drops as EXPAND is entered
    k = rand_key();
    accept(k);
    check("from done o_done", 128'(done), '0);
    check_rounds("from done", -1, 1'b0, '0, '0);

    // start during EXPAND at round 4 is ignored
    accept(vecs[0].key);
    check_rounds("restart r4", 4, 1'b1, vecs[0].r1, vecs[0].r10);

    // Reset at round 5 aborts; valid stays low until a new start
    accept(vecs[0].key);
    for (int r = 0; r < 5; r++) step();
    check("pre-reset idx", 128'(round_idx), 128'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("mid reset");
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      vcount += int'(key_valid);
    end
    check("post reset valid count", 128'(vcount), '0);
    accept(vecs[1].key);
    check_rounds("after reset", -1, 1'b1, vecs[1].r1, vecs[1].r10);

    // start held with reset is ignored, accepted on first edge after release
    k     = rand_key();
    compute_model(k);
    key   = k;
    start = 1'b1;
    rst   = 1'b1;
    step();
    check_idle("rst+start");
    rst = 1'b0;
    step();
    start = 1'b0;
    key   = rand_key();
    check_rounds("start after rst", -1, 1'b0, '0, '0);

    // Random keys against the model
    for (int n = 0; n < 6; n++) begin
      accept(rand_key());
      check_rounds($sformatf("rand%0d", n), (n % 2 == 0) ? int'($urandom_range(0, 10)) : -1,
                   1'b0, '0, '0);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
